// File: rtl/trace_dump_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_dump_uart_if
// Description : Dump control, RAM read port and UART line of trace_dump_uart.
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_dump_uart_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_q;
  logic              uart_tx;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, ram_q,
    input  ram_addr, uart_tx, busy, done
  );

  modport slave (
    input  start, start_addr, ram_q,
    output ram_addr, uart_tx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/trace_dump_uart.sv
`default_nettype none
// ============================================================================
// Module      : trace_dump_uart
// Description : Walks the 64-entry capture RAM once and dumps it on UART 8N1.
//               TRACE_DUMP_HEX_EN selects ASCII hex output with CR/LF tail.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_dump_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 6,
  parameter int RD_LAT       = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  trace_dump_uart_if.slave  bus
);

  localparam int c_BAUD_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int c_ENTRIES = 2 ** ADDR_W;

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST  = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_LAT_W-1:0]  c_LAT_LAST   = c_LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W:0]     c_ENTRIES_V  = (ADDR_W + 1)'(c_ENTRIES);
  localparam logic [ADDR_W:0]     c_LAST_ENTRY = (ADDR_W + 1)'(c_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    NEXT  = 3'd5
  } state_t;

  state_t              r_state,  w_state;
  logic [c_BAUD_W-1:0] r_baud,   w_baud;
  logic [c_LAT_W-1:0]  r_lat,    w_lat;
  logic [2:0]          r_bit,    w_bit;
  logic [ADDR_W:0]     r_entry,  w_entry;
  logic [ADDR_W-1:0]   r_addr,   w_addr;
  logic [7:0]          r_shift,  w_shift;
  logic                r_tx,     w_tx;
  logic                r_busy,   w_busy;
  logic                r_done,   w_done;
  logic                w_bit_end;
  logic                w_last_frame;
  logic [ADDR_W:0]     w_entry_inc;

`ifdef TRACE_DUMP_HEX_EN
  // Phase of the current entry: 0 high nibble, 1 low nibble, 2 CR, 3 LF.
  logic [1:0]          r_phase,  w_phase;
  logic [7:0]          r_byte,   w_byte;

  function automatic logic [7:0] f_hex(input logic [3:0] i_nib);
    f_hex = (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib}) : (8'h37 + {4'h0, i_nib});
  endfunction

  assign w_last_frame = (r_phase == 2'd3);
`else
  assign w_last_frame = (r_entry == c_LAST_ENTRY);
`endif

  assign w_bit_end   = (r_baud == c_BAUD_LAST);
  assign w_entry_inc = r_entry + 1'b1;

  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_lat   = r_lat;
    w_bit   = r_bit;
    w_entry = r_entry;
    w_addr  = r_addr;
    w_shift = r_shift;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_tx    = 1'b1;
`ifdef TRACE_DUMP_HEX_EN
    w_phase = r_phase;
    w_byte  = r_byte;
`endif

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_addr  = bus.start_addr;
          w_entry = '0;
          w_lat   = '0;
          w_busy  = 1'b1;
          w_state = FETCH;
`ifdef TRACE_DUMP_HEX_EN
          w_phase = 2'd0;
`endif
        end
      end

      FETCH: begin
        if (r_lat == c_LAT_LAST) begin
          w_lat   = '0;
          w_baud  = '0;
          w_state = START;
`ifdef TRACE_DUMP_HEX_EN
          w_byte  = bus.ram_q;
          w_shift = f_hex(bus.ram_q[7:4]);
`else
          w_shift = bus.ram_q;
`endif
        end else begin
          w_lat = r_lat + 1'b1;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_bit   = '0;
          w_state = DATA;
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_shift = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state = STOP;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_state = NEXT;
          // Done is raised one cycle early so it lines up with the NEXT cycle.
          w_done  = w_last_frame;
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      NEXT: begin
`ifdef TRACE_DUMP_HEX_EN
        case (r_phase)
          2'd0: begin
            w_phase = 2'd1;
            w_shift = f_hex(r_byte[3:0]);
            w_state = START;
          end
          2'd1: begin
            w_entry = w_entry_inc;
            w_addr  = r_addr + 1'b1;
            if (w_entry_inc == c_ENTRIES_V) begin
              w_phase = 2'd2;
              w_shift = 8'h0D;
              w_state = START;
            end else begin
              w_phase = 2'd0;
              w_lat   = '0;
              w_state = FETCH;
            end
          end
          2'd2: begin
            w_phase = 2'd3;
            w_shift = 8'h0A;
            w_state = START;
          end
          default: begin
            w_phase = 2'd0;
            w_busy  = 1'b0;
            w_state = IDLE;
          end
        endcase
`else
        w_entry = w_entry_inc;
        w_addr  = r_addr + 1'b1;
        if (w_entry_inc == c_ENTRIES_V) begin
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_lat   = '0;
          w_state = FETCH;
        end
`endif
      end

      default: begin
        w_state = IDLE;
      end
    endcase

    // Line level follows the state being entered so tx is glitch-free.
    case (w_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_shift[0];
      default: w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_lat   <= '0;
      r_bit   <= '0;
      r_entry <= '0;
      r_addr  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef TRACE_DUMP_HEX_EN
      r_phase <= 2'd0;
      r_byte  <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_lat   <= w_lat;
      r_bit   <= w_bit;
      r_entry <= w_entry;
      r_addr  <= w_addr;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
`ifdef TRACE_DUMP_HEX_EN
      r_phase <= w_phase;
      r_byte  <= w_byte;
`endif
    end
  end

  assign bus.ram_addr = r_addr;
  assign bus.uart_tx  = r_tx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_trace_dump_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_dump_uart
// Description : Self-checking bench for trace_dump_uart (raw or hex build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_dump_uart;

  localparam int CPB     = 4;
  localparam int ADDR_W  = 6;
  localparam int RD_LAT  = 2;
  localparam int ENTRIES = 64;
  localparam int WAIT_MAX = 200;

  logic clk;
  logic rst_n;

  trace_dump_uart_if #(.ADDR_W(ADDR_W)) bus ();

  trace_dump_uart #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (ADDR_W),
    .RD_LAT       (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture RAM: one output register stage gives data RD_LAT edges after address.
  logic [7:0] mem [ENTRIES];
  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  int  cyc;
  int  n_done;
  int  done_cyc;
  bit  busy_drop;
  int  errors;
  int  checks;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic void build_exp(input int sa);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < ENTRIES; k++) begin
      b = mem[(sa + k) % ENTRIES];
`ifdef TRACE_DUMP_HEX_EN
      exp_q.push_back(hex_char(int'(b) / 16));
      exp_q.push_back(hex_char(int'(b) % 16));
`else
      exp_q.push_back(b);
`endif
    end
`ifdef TRACE_DUMP_HEX_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  // Finds a start bit, then samples every clock of the 10-bit frame.
  task automatic recv_frame(output logic [7:0] data, output logic [2:0] shape, output bit ok);
    logic [9:0] bits;
    logic       s;
    bit         stable;
    ok = 1'b0; data = '0; shape = '0; stable = 1'b1; bits = '0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_drop = 1'b1;
      if (bus.uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) begin
          @(negedge clk);
          if (bus.busy !== 1'b1) busy_drop = 1'b1;
        end
        s = bus.uart_tx;
        if (c == 0) bits[b] = s;
        else if (s !== bits[b]) stable = 1'b0;
      end
    end
    data  = bits[8:1];
    shape = {bits[0], bits[9], stable};
  endtask

  task automatic run_dump(input int sa, input int inject_at, input bit inject_done, input string tag);
    logic [7:0] d;
    logic [2:0] shape;
    bit         ok;
    int         t0;
    int         nd0;
    build_exp(sa);
    busy_drop = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = ADDR_W'(sa);
    t0  = cyc;
    nd0 = n_done;
    @(negedge clk);
    bus.start = 1'b0;
    bus.start_addr = ADDR_W'($urandom);
    for (int f = 0; f < exp_q.size(); f++) begin
      recv_frame(d, shape, ok);
      if (!ok) begin
        chk({tag, "_start_timeout"}, 32'(f), 32'hFFFF_FFFF);
        return;
      end
      chk($sformatf("%s_frame%0d", tag, f), 32'(d), 32'(exp_q[f]));
      chk($sformatf("%s_shape%0d", tag, f), 32'(shape), 32'b011);
      if (f == inject_at) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.start_addr = 6'd10;
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_done_after_stop"}, 32'(bus.done), 32'd1);
    if (inject_done) begin
      bus.start = 1'b1;
      bus.start_addr = 6'd10;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_after_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
    repeat (5) @(negedge clk);
    chk({tag, "_idle_after"}, {30'd0, bus.busy, bus.uart_tx}, 32'b01);
    chk({tag, "_done_count"}, 32'(n_done - nd0), 32'd1);
    chk({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
`ifndef TRACE_DUMP_HEX_EN
    chk({tag, "_length"}, 32'(done_cyc - t0 + 1), 32'(ENTRIES * (10 * CPB + RD_LAT + 1) + 1));
`endif
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] shape;
    bit         ok;
    bit         act;
    errors = 0; checks = 0; n_done = 0; done_cyc = 0; cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.start_addr = '0;
    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(bus.uart_tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    rst_n = 1'b1;
    act = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) act = 1'b1;
    end
    chk("idle_quiet", 32'(act), 32'd0);

    mem[5] = 8'h3D;
    run_dump(5, -1, 1'b0, "single");

    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'(i);
    run_dump(62, -1, 1'b0, "wrap");

    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'($urandom);
    run_dump(int'($urandom_range(0, ENTRIES - 1)), 21, 1'b1, "busy_start");

    // Reset in the middle of a frame whose data bits are all zero.
    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'($urandom);
    mem[2] = 8'h00;
    build_exp(0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = '0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      recv_frame(d, shape, ok);
      chk($sformatf("pre_rst_frame%0d", f), {23'd0, ok, d}, {23'd0, 1'b1, exp_q[f]});
    end
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (bus.uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pre_rst_start_seen", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    chk("pre_rst_line_low", 32'(bus.uart_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(bus.uart_tx), 32'd1);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_addr", 32'(bus.ram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'($urandom);
    run_dump(0, -1, 1'b0, "post_rst");

    for (int i = 0; i < ENTRIES; i++) mem[i] = 8'hA7;
    run_dump(0, -1, 1'b0, "fill_a7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
